// File: rtl/acc_bram_array.sv
// -----------------------------------------------------------------------------
// acc_bram_array
//
// Multi-lane accumulator memory between the systolic array's partial-sum
// outputs and the output path. Each accepted write either overwrites one entry
// or accumulates into it. A two-stage read-modify-write pipeline forwards the
// committing result straight into the next op when both target the same
// address, so back-to-back accumulates run at one op per cycle. The block also
// has a registered read port (port B), a hardware clear sweep and a sticky
// overflow flag.
//
// Optional feature macro: ACC_SATURATE_EN
//   defined     : an overflowing lane clamps to the signed ACC_WIDTH limits
//   not defined : an overflowing lane wraps (two's-complement truncation)
//   In both builds the sticky ovf flag is raised.
//
// Ports
//   clk          in   sole clock, rising edge
//   reset        in   synchronous active-high reset (memory contents kept)
//   wea          in   write request, taken when ready is high
//   acc_en       in   with wea: 1 accumulate, 0 overwrite
//   addra        in   write address
//   dina         in   write data, lane i at [i*IN_WIDTH +: IN_WIDTH]
//   ready        out  write port accepts requests (IDLE and not in reset)
//   enb          in   read request
//   addrb        in   read address
//   doutb        out  registered read data, holds when enb is low
//   doutb_valid  out  doutb carries data for a read sampled on the last edge
//   clear        in   pulse: zero the whole array (ignored unless IDLE)
//   busy         out  clear sequence in progress
//   ovf          out  sticky: some lane overflowed since last reset/clear
// -----------------------------------------------------------------------------
module acc_bram_array #(
  parameter int LANES      = 16,
  parameter int IN_WIDTH   = 20,
  parameter int ACC_WIDTH  = 20,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wea,
  input  logic                         acc_en,
  input  logic [ADDR_WIDTH-1:0]        addra,
  input  logic [LANES*IN_WIDTH-1:0]    dina,
  output logic                         ready,
  input  logic                         enb,
  input  logic [ADDR_WIDTH-1:0]        addrb,
  output logic [LANES*ACC_WIDTH-1:0]   doutb,
  output logic                         doutb_valid,
  input  logic                         clear,
  output logic                         busy,
  output logic                         ovf
);

  localparam int DW = LANES * ACC_WIDTH;
  localparam int IW = LANES * IN_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Per-lane arithmetic helpers
  // ---------------------------------------------------------------------------

  // Raw lane result at ACC_WIDTH+1 bits: sign-extended input, optionally
  // added to the sign-extended old value. One extra bit cannot overflow.
  function automatic logic [ACC_WIDTH:0] lane_wide(
    input logic [ACC_WIDTH-1:0] old_v,
    input logic [IN_WIDTH-1:0]  din_v,
    input logic                 acc_v
  );
    logic [ACC_WIDTH:0] din_x;
    logic [ACC_WIDTH:0] old_x;
    din_x = {{(ACC_WIDTH + 1 - IN_WIDTH){din_v[IN_WIDTH-1]}}, din_v};
    old_x = {old_v[ACC_WIDTH-1], old_v};
    if (acc_v) begin
      return old_x + din_x;
    end else begin
      return din_x;
    end
  endfunction

  // The wide result leaves the signed ACC_WIDTH range exactly when its two
  // top bits disagree.
  function automatic logic lane_over(input logic [ACC_WIDTH:0] wide_v);
    return wide_v[ACC_WIDTH] ^ wide_v[ACC_WIDTH-1];
  endfunction

  // Fold the wide result back to ACC_WIDTH bits (clamp or wrap on overflow).
  function automatic logic [ACC_WIDTH-1:0] lane_fit(input logic [ACC_WIDTH:0] wide_v);
    logic [ACC_WIDTH-1:0] r;
`ifdef ACC_SATURATE_EN
    if (lane_over(wide_v)) begin
      // The extra top bit is the true sign: negative clamps to min, else max.
      if (wide_v[ACC_WIDTH]) begin
        r = {1'b1, {(ACC_WIDTH - 1){1'b0}}};
      end else begin
        r = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
      end
    end else begin
      r = wide_v[ACC_WIDTH-1:0];
    end
`else
    r = wide_v[ACC_WIDTH-1:0];
`endif
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [DW-1:0]          mem_q [DEPTH];

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  clr_cnt_q, clr_cnt_d;

  // Op captured on its accept edge; it commits to memory on the next edge.
  logic                   s1_valid_q;
  logic                   s1_acc_q;
  logic [ADDR_WIDTH-1:0]  s1_addr_q;
  logic [IW-1:0]          s1_din_q;
  logic [DW-1:0]          s1_old_q, s1_old_d;

  logic [DW-1:0]          res_s;
  logic [LANES-1:0]       lane_ovf_s;

  logic                   ready_s;
  logic                   accept_s;

  logic                   mem_we_s;
  logic [ADDR_WIDTH-1:0]  mem_waddr_s;
  logic [DW-1:0]          mem_wdata_s;

  logic                   ovf_q, ovf_d;
  logic [DW-1:0]          doutb_q;
  logic                   doutb_valid_q;

  assign ready_s  = (state_q == ST_IDLE) && !reset;
  assign accept_s = wea && ready_s;

  assign ready       = ready_s;
  assign busy        = (state_q != ST_IDLE);
  assign ovf         = ovf_q;
  assign doutb       = doutb_q;
  assign doutb_valid = doutb_valid_q;

  // ---------------------------------------------------------------------------
  // Commit stage arithmetic
  // ---------------------------------------------------------------------------

  // Lane results and overflow flags for the op committing on the next edge.
  always_comb begin
    res_s      = '0;
    lane_ovf_s = '0;
    for (int i = 0; i < LANES; i++) begin
      res_s[i*ACC_WIDTH +: ACC_WIDTH] = lane_fit(lane_wide(
        s1_old_q[i*ACC_WIDTH +: ACC_WIDTH], s1_din_q[i*IN_WIDTH +: IN_WIDTH], s1_acc_q));
      lane_ovf_s[i] = lane_over(lane_wide(
        s1_old_q[i*ACC_WIDTH +: ACC_WIDTH], s1_din_q[i*IN_WIDTH +: IN_WIDTH], s1_acc_q));
    end
  end

  // Old value for a newly accepted op: the memory write on this same edge is
  // not yet visible, so a same-address commit is forwarded from res_s.
  always_comb begin
    if (s1_valid_q && (s1_addr_q == addra)) begin
      s1_old_d = res_s;
    end else begin
      s1_old_d = mem_q[addra];
    end
  end

  // Capture register for accepted write requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_acc_q   <= 1'b0;
      s1_addr_q  <= '0;
      s1_din_q   <= '0;
      s1_old_q   <= '0;
    end else begin
      s1_valid_q <= accept_s;
      if (accept_s) begin
        s1_acc_q  <= acc_en;
        s1_addr_q <= addra;
        s1_din_q  <= dina;
        s1_old_q  <= s1_old_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Single memory write port: clear sweep or pipeline commit
  // ---------------------------------------------------------------------------

  // Select the write source; reset suppresses any write on its edge so an
  // interrupted sweep or in-flight op leaves memory untouched.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = s1_addr_q;
    mem_wdata_s = res_s;
    if (reset) begin
      mem_we_s = 1'b0;
    end else if (state_q == ST_CLEAR) begin
      // No op can be in flight here: DRAIN committed the last one.
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_cnt_q;
      mem_wdata_s = '0;
    end else if (s1_valid_q) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Memory array write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port B (read-first against a same-edge write)
  // ---------------------------------------------------------------------------

  // Registered read data and its one-cycle valid strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      doutb_q       <= '0;
      doutb_valid_q <= 1'b0;
    end else begin
      doutb_valid_q <= enb;
      if (enb) begin
        doutb_q <= mem_q[addrb];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------

  // Next state and sweep counter.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
      ST_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Sticky overflow: cleared on the DRAIN->CLEAR edge, which wins over an
  // overflow from the op draining on that same edge.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == ST_DRAIN) begin
      ovf_d = 1'b0;
    end else if (s1_valid_q && (|lane_ovf_s)) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Sequencer state, sweep counter and overflow flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_acc_bram_array.sv
// Self-checking bench for acc_bram_array: a behavioural memory model predicts
// read data and status; read expectations go through a scoreboard queue that
// a separate monitor drains whenever doutb_valid is high.
module tb_acc_bram_array;

  localparam int LANES = 16;
  localparam int IW    = 20;
  localparam int AW    = 20;
  localparam int DEPTH = 256;
  localparam int ADDRW = 8;
  localparam int DW    = LANES * AW;

  logic              clk;
  logic              reset;
  logic              wea;
  logic              acc_en;
  logic [ADDRW-1:0]  addra;
  logic [LANES*IW-1:0] dina;
  logic              ready;
  logic              enb;
  logic [ADDRW-1:0]  addrb;
  logic [DW-1:0]     doutb;
  logic              doutb_valid;
  logic              clear;
  logic              busy;
  logic              ovf;

  acc_bram_array dut (
    .clk(clk), .reset(reset), .wea(wea), .acc_en(acc_en), .addra(addra),
    .dina(dina), .ready(ready), .enb(enb), .addrb(addrb), .doutb(doutb),
    .doutb_valid(doutb_valid), .clear(clear), .busy(busy), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architected memory contents and status.
  int            ref_mem [DEPTH][LANES];
  bit            pend_v;
  bit            pend_acc;
  int            pend_addr;
  int            pend_din [LANES];
  int            m_cyc;       // 0 idle, 1 drain, 2..DEPTH+1 zeroing entry m_cyc-2
  bit            m_ovf;
  int            din_lane [LANES];

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] hold_vec;
  bit            mon_en;
  bit            ovr_en;
  logic [DW-1:0] ovr_vec;

  int n_checks;
  int n_fail;

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int fit_lane(input longint v, output bit of);
    longint mx;
    longint mn;
    mx = (longint'(1) <<< (AW - 1)) - 1;
    mn = -(longint'(1) <<< (AW - 1));
    of = 1'b0;
    if (v > mx) begin
      of = 1'b1;
`ifdef ACC_SATURATE_EN
      return int'(mx);
`else
      return int'(v - (longint'(1) <<< AW));
`endif
    end else if (v < mn) begin
      of = 1'b1;
`ifdef ACC_SATURATE_EN
      return int'(mn);
`else
      return int'(v + (longint'(1) <<< AW));
`endif
    end
    return int'(v);
  endfunction

  function automatic logic [DW-1:0] vec_all(input int v);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*AW +: AW] = AW'(v);
    return r;
  endfunction

  task automatic set_din_all(input int v);
    for (int i = 0; i < LANES; i++) din_lane[i] = v;
    for (int i = 0; i < LANES; i++) dina[i*IW +: IW] = IW'(din_lane[i]);
  endtask

  task automatic set_din_cur();
    for (int i = 0; i < LANES; i++) dina[i*IW +: IW] = IW'(din_lane[i]);
  endtask

  task automatic idle_in();
    wea = 1'b0; acc_en = 1'b0; enb = 1'b0; clear = 1'b0; reset = 1'b0;
  endtask

  // Advance one clock: update the model for the upcoming edge, then check status.
  task automatic step();
    logic [DW-1:0] e;
    longint        v;
    bit            of;
    bit            rdy;
    bit            rd_now;
    rd_now = enb && !reset;
    if (reset) begin
      pend_v = 1'b0;
      m_cyc  = 0;
      m_ovf  = 1'b0;
    end else begin
      if (enb) begin
        for (int i = 0; i < LANES; i++) e[i*AW +: AW] = AW'(ref_mem[addrb][i]);
        if (ovr_en) e = ovr_vec;
        exp_q.push_back(e);
        ovr_en = 1'b0;
      end
      if (pend_v) begin
        for (int i = 0; i < LANES; i++) begin
          v = pend_acc ? longint'(ref_mem[pend_addr][i]) + longint'(pend_din[i])
                       : longint'(pend_din[i]);
          ref_mem[pend_addr][i] = fit_lane(v, of);
          if (of) m_ovf = 1'b1;
        end
        pend_v = 1'b0;
      end
      if (m_cyc >= 2) begin
        for (int i = 0; i < LANES; i++) ref_mem[m_cyc-2][i] = 0;
      end
      rdy = (m_cyc == 0);
      if (m_cyc == 1) m_ovf = 1'b0;
      if (m_cyc == 0) m_cyc = clear ? 1 : 0;
      else if (m_cyc == DEPTH + 1) m_cyc = 0;
      else m_cyc++;
      if (wea && rdy) begin
        pend_v    = 1'b1;
        pend_acc  = acc_en;
        pend_addr = int'(addra);
        for (int i = 0; i < LANES; i++) pend_din[i] = din_lane[i];
      end
    end
    @(posedge clk);
    #1;
    if (reset) begin
      hold_vec = '0;
      mon_en   = 1'b1;
    end
    chk_bit("ready", ready, (m_cyc == 0) && !reset);
    chk_bit("busy", busy, m_cyc != 0);
    chk_bit("ovf", ovf, m_ovf);
    chk_bit("doutb_valid", doutb_valid, rd_now);
  endtask

  task automatic do_write(input int a, input bit acc, input int v);
    idle_in();
    wea = 1'b1; acc_en = acc; addra = ADDRW'(a);
    set_din_all(v);
    step();
  endtask

  task automatic do_read(input int a, input bit use_ovr, input logic [DW-1:0] ev);
    idle_in();
    enb = 1'b1; addrb = ADDRW'(a);
    ovr_en = use_ovr; ovr_vec = ev;
    step();
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) begin
      idle_in();
      step();
    end
  endtask

  // Step until busy drops, bounded; returns busy cycles seen including the first.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      if (busy !== 1'b1) return;
      cnt++;
      idle_in();
      step();
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_idle: busy still %b after 400 cycles", busy);
  endtask

  // Scoreboard monitor: compare every valid read, and require doutb to hold otherwise.
  always @(negedge clk) begin
    if (doutb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL read_unexpected: got %h expected no read at %0t", doutb, $time);
      end else begin
        hold_vec = exp_q.pop_front();
        chk_vec("read_data", doutb, hold_vec);
      end
    end else if (mon_en) begin
      chk_vec("doutb_hold", doutb, hold_vec);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            cnt;
    logic [DW-1:0] ev;
    n_checks = 0; n_fail = 0;
    mon_en = 1'b0; ovr_en = 1'b0; hold_vec = '0;
    pend_v = 1'b0; m_cyc = 0; m_ovf = 1'b0;
    addra = '0; addrb = '0;
    for (int a = 0; a < DEPTH; a++)
      for (int i = 0; i < LANES; i++) ref_mem[a][i] = 0;
    set_din_all(0);
    idle_in();

    // Reset state.
    reset = 1'b1;
    step();
    step();
    chk_vec("reset_doutb", doutb, '0);

    // Zero the (unknown) array so the model matches from here on.
    idle_in(); clear = 1'b1; step();
    wait_idle(cnt);

    // Overwrite addr 5 with lane j = j-3, read two cycles later.
    idle_in();
    wea = 1'b1; acc_en = 1'b0; addra = 8'd5;
    for (int i = 0; i < LANES; i++) din_lane[i] = i - 3;
    set_din_cur();
    step();
    idle_steps(1);
    for (int i = 0; i < LANES; i++) ev[i*AW +: AW] = AW'(i - 3);
    do_read(5, 1'b1, ev);
    idle_steps(2);

    // 100 then three back-to-back +1 accumulates.
    do_write(7, 1'b0, 100);
    do_write(7, 1'b1, 1);
    do_write(7, 1'b1, 1);
    do_write(7, 1'b1, 1);
    idle_steps(1);
    do_read(7, 1'b1, vec_all(103));
    idle_steps(2);

    // Max positive plus one.
    do_write(9, 1'b0, 524287);
    do_write(9, 1'b1, 1);
    idle_steps(1);
`ifdef ACC_SATURATE_EN
    do_read(9, 1'b1, vec_all(524287));
`else
    do_read(9, 1'b1, vec_all(-524288));
`endif
    idle_steps(2);

    // Read-first on the commit edge.
    do_write(3, 1'b0, 77);
    idle_steps(1);
    do_write(3, 1'b0, 10);
    do_read(3, 1'b1, vec_all(77));
    do_read(3, 1'b1, vec_all(10));
    idle_steps(2);

    // Clear sweep with a dropped write during busy (ovf is set from above).
    do_write(0, 1'b0, 42);
    do_write(255, 1'b0, 42);
    idle_steps(2);
    idle_in(); clear = 1'b1; step();
    cnt = 0;
    idle_in(); wea = 1'b1; acc_en = 1'b0; addra = 8'd100; set_din_all(55);
    cnt = (busy === 1'b1) ? 1 : 0;
    step();
    for (int k = 0; k < 40; k++) begin
      idle_in();
      enb = 1'b1; addrb = ADDRW'(k);
      if (busy === 1'b1) cnt++;
      step();
    end
    begin
      int rest;
      wait_idle(rest);
      cnt += rest;
    end
    n_checks++;
    if (cnt != DEPTH + 1) begin
      n_fail++;
      $display("FAIL clear_busy_len: got %0d expected %0d", cnt, DEPTH + 1);
    end
    do_read(0, 1'b1, vec_all(0));
    do_read(255, 1'b1, vec_all(0));
    do_read(100, 1'b1, vec_all(0));
    idle_steps(2);

    // Randomized traffic over a small address window to exercise forwarding.
    for (int k = 0; k < 700; k++) begin
      idle_in();
      wea    = 1'($urandom_range(1));
      acc_en = 1'($urandom_range(3) != 0);
      addra  = ADDRW'($urandom_range(7));
      for (int i = 0; i < LANES; i++) begin
        if ($urandom_range(3) == 0) din_lane[i] = int'($urandom_range(1048575)) - 524288;
        else din_lane[i] = int'($urandom_range(200)) - 100;
      end
      set_din_cur();
      enb   = 1'($urandom_range(1));
      addrb = ADDRW'($urandom_range(9));
      clear = 1'($urandom_range(299) == 0);
      step();
    end
    idle_steps(1);
    wait_idle(cnt);
    idle_steps(2);

    // Reset ten cycles into the sweep over data 42.
    for (int a = 0; a < 10; a++) do_write(a, 1'b0, 42);
    do_write(200, 1'b0, 42);
    idle_steps(2);
    idle_in(); clear = 1'b1; step();
    idle_steps(11);
    idle_in(); reset = 1'b1; step();
    chk_vec("reset_mid_clear_doutb", doutb, '0);
    idle_in();
    for (int a = 0; a < 8; a++) do_read(a, 1'b1, vec_all(0));
    do_read(200, 1'b1, vec_all(42));
    do_read(12, 1'b0, '0);
    idle_steps(3);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending reads expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
